// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: command FIFO plus issue/capture sequencer around a
// combinational alu. Commands {op1, op2, opcode} are buffered, issued one at
// a time through registered operand/operation outputs, and the alu result is
// captured and handed downstream in command order.
// Optional feature macro: ALU_DIVZERO_TRAP_EN (divide/modulo-by-zero trap).
`timescale 1ns/1ps

module alu_issue_ctrl #(
    parameter int N     = 4,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N-1:0]               in_op1,
    input  logic [N-1:0]               in_op2,
    input  logic [3:0]                 in_opcode,
    output logic [N-1:0]               operand1,
    output logic [N-1:0]               operand2,
    output logic [N-1:0]               operation,
    input  logic [2*N-1:0]             alu_out,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [2*N-1:0]             out_result,
    output logic [3:0]                 out_opcode,
    output logic                       out_err,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t          state_q, state_d;

    // Command storage; payload is not reset, only pointers and count are.
    logic [N-1:0]    op1_mem [DEPTH];
    logic [N-1:0]    op2_mem [DEPTH];
    logic [3:0]      opc_mem [DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;

    logic [N-1:0]    operand1_q, operand2_q, operation_q;
    logic            out_valid_q;
    logic [2*N-1:0]  out_result_q;
    logic [3:0]      out_opcode_q;
    logic            out_err_q;

    logic            fifo_empty;
    logic            push;
    logic            pop;
    logic            load_res;
    logic            clr_valid;
    logic [2*N-1:0]  result_d;
    logic            err_d;

    assign fifo_empty = (count_q == '0);
    assign in_ready   = (count_q != CW'(DEPTH));
    assign push       = in_valid && in_ready;

    assign operand1   = operand1_q;
    assign operand2   = operand2_q;
    assign operation  = operation_q;
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_opcode = out_opcode_q;
    assign out_err    = out_err_q;
    assign fifo_count = count_q;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: issue when work is queued, wait for the consumer after capture.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (!fifo_empty) state_d = S_EXEC;
            S_EXEC: state_d = S_WAIT;
            S_WAIT: begin
                if (out_ready) begin
                    state_d = fifo_empty ? S_IDLE : S_EXEC;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: pop the FIFO head on issue, capture in EXEC, drop valid on consume.
    always_comb begin
        pop       = 1'b0;
        load_res  = 1'b0;
        clr_valid = 1'b0;
        case (state_q)
            S_IDLE: pop = !fifo_empty;
            S_EXEC: load_res = 1'b1;
            S_WAIT: begin
                clr_valid = out_ready;
                pop       = out_ready && !fifo_empty;
            end
            default: ;
        endcase
    end

    // Result selection; the optional trap replaces a divide/modulo by zero.
`ifdef ALU_DIVZERO_TRAP_EN
    always_comb begin
        err_d    = ((operation_q[3:0] == 4'b0011) || (operation_q[3:0] == 4'b0100))
                   && (operand2_q == '0);
        result_d = err_d ? '0 : alu_out;
    end
`else
    always_comb begin
        err_d    = 1'b0;
        result_d = alu_out;
    end
`endif

    // FIFO payload write.
    always_ff @(posedge clk) begin
        if (push) begin
            op1_mem[wr_ptr_q] <= in_op1;
            op2_mem[wr_ptr_q] <= in_op2;
            opc_mem[wr_ptr_q] <= in_opcode;
        end
    end

    // FIFO pointers and occupancy; simultaneous push/pop leaves the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Issue registers: load the FIFO head on pop, otherwise hold the last issued command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            operand1_q  <= '0;
            operand2_q  <= '0;
            operation_q <= '0;
        end else if (pop) begin
            operand1_q  <= op1_mem[rd_ptr_q];
            operand2_q  <= op2_mem[rd_ptr_q];
            operation_q <= N'(opc_mem[rd_ptr_q]);
        end
    end

    // Result registers: capture at the end of EXEC, hold stable until consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_opcode_q <= '0;
            out_err_q    <= 1'b0;
        end else if (load_res) begin
            out_valid_q  <= 1'b1;
            out_result_q <= result_d;
            out_opcode_q <= operation_q[3:0];
            out_err_q    <= err_d;
        end else if (clr_valid) begin
            out_valid_q  <= 1'b0;
        end
    end

endmodule
